serialize_stream: RTL and testbench
===================================

Name: serialize_stream

Overview:
Parametrised successor to the single-shot ciphertext serializer. It accepts a MSG_SIZE-bit ciphertext word through a valid/ready load handshake and shifts it out one bit per enabled clock, in a bit order selected per frame. Each bit is marked with a per-bit valid strobe, the last bit carries a one-cycle done pulse, and completed frames are counted. It sits between the XOR encrypt stage and the serial output pin, and supports back-to-back frames, stall and abort.

Parameters:
MSG_SIZE, 8, ciphertext width in bits; legal range is 2 or more.
FCNT_W, 8, width of the completed-frame counter.

Ports:
iClk  input  1  system clock (half_clock domain).
iRst  input  1  asynchronous, active-low reset.
iEn  input  1  clock enable; when low, the block stalls.
iAbort  input  1  synchronous abort of the current frame.
iValid  input  1  ciphertext word available for loading.
oReady  output  1  block can accept a word; combinational, equal to (state==IDLE).
iMsb_first  input  1  bit order, sampled at load: 1 = MSB first, 0 = LSB first.
iCiphertext  input  MSG_SIZE  word to serialize; sampled only at load.
oData  output  1  serial data bit.
oBit_valid  output  1  oData holds a new frame bit this cycle.
oDone_flag  output  1  one-cycle pulse coincident with the last bit of a frame.
oBusy  output  1  frame in progress (state==SHIFT).
oFrame_cnt  output  FCNT_W  number of completed frames; wraps modulo 2^FCNT_W.

Behaviour:
- Reset (iRst=0, async): state=IDLE; shift register=0; bit counter=0; oData=0; oBit_valid=0; oDone_flag=0; oFrame_cnt=0. Consequently oReady=1 and oBusy=0.
- States: IDLE and SHIFT. All registered outputs update on the posedge of iClk.
- IDLE:
  - Load occurs when iEn=1, iValid=1 and iAbort=0 (oReady is 1 in IDLE).
  - Load captures iCiphertext into the shift register, latches iMsb_first, clears the bit counter, and moves to SHIFT.
  - The load cycle emits no bit: oBit_valid=0 and oDone_flag=0, and oData holds its previous value.
- SHIFT, on each cycle with iEn=1:
  - oData <= shreg[MSG_SIZE-1] when MSB-first, shreg[0] when LSB-first.
  - The register shifts toward the emitted end; the counter increments; oBit_valid <= 1.
  - When counter==MSG_SIZE-1, the last bit is emitted. In that same edge: oDone_flag <= 1, oFrame_cnt increments, state goes to IDLE.
  - Otherwise oDone_flag <= 0.
- Timing: first bit is visible on the edge after load; a frame spans MSG_SIZE+1 enabled cycles including the load. Back-to-back throughput is one frame per MSG_SIZE+1 enabled cycles, because oReady rises in the cycle after the last bit.
- Stall (iEn=0): state, counter, shift register, oData and oFrame_cnt all hold. oBit_valid and oDone_flag are forced to 0, so no bit is double-counted. A stall never ends a frame early.
- Abort (iAbort=1, sampled regardless of iEn):
  - Next state=IDLE; counter cleared; oBit_valid=0; oDone_flag=0.
  - oFrame_cnt does not increment, and oData is driven to 0.
  - Abort takes priority over a last-bit emission in the same cycle: no done pulse, no count.
  - Abort in IDLE suppresses a load in that cycle.
- Mid-frame: changes on iCiphertext or iMsb_first have no effect on the frame in progress. iValid is ignored while in SHIFT.
- Counter width is $clog2(MSG_SIZE), minimum 1; it never exceeds MSG_SIZE-1.
- oFrame_cnt wraps from all-ones to 0 without a flag.
- Reset mid-frame returns immediately to reset values; there is no partial done.

Test Plan:
- Reset, then load 8'hA5 with LSB-first and iEn=1 -> oData sequence 1,0,1,0,0,1,0,1 on the 8 cycles after load; oBit_valid=1 on each; oDone_flag=1 only on the 8th bit; oFrame_cnt=1; oReady=1 on the following cycle.
- Same word with MSB-first -> sequence 1,0,1,0,0,1,0,1 (MSB 1 first, then 0,1,0,0,1,0,1); confirm bit 7 comes first by also sending 8'h80 -> 1,0,0,0,0,0,0,0.
- Load 8'hFF and drop iEn for 3 cycles after bit 3 -> oData holds 1 with oBit_valid=0 during the stall; exactly 8 valid strobes; a single done pulse.
- Assert iAbort at bit 5 of 8'h3C -> next cycle IDLE, oData=0, no oDone_flag, oFrame_cnt unchanged; the next load serializes normally.
- iValid held high for 3 frames (8'h01, 8'h02, 8'h03) -> frames start every 9 cycles; 3 done pulses; oFrame_cnt=3. With FCNT_W=2, 5 frames -> oFrame_cnt=1.
- Assert iRst during bit 4 -> all outputs return to reset values asynchronously; after release, a fresh load of 8'h5A serializes correctly.

Source files
------------

// File: rtl/serialize_stream.sv
// Ciphertext word serializer: valid/ready load, per-frame bit order, stall/abort,
// per-bit valid strobe, last-bit done pulse and a wrapping completed-frame counter.
module serialize_stream #(
  parameter int unsigned MSG_SIZE = 8,
  parameter int unsigned FCNT_W   = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iAbort,
  input  logic                iValid,
  output logic                oReady,
  input  logic                iMsb_first,
  input  logic [MSG_SIZE-1:0] iCiphertext,
  output logic                oData,
  output logic                oBit_valid,
  output logic                oDone_flag,
  output logic                oBusy,
  output logic [FCNT_W-1:0]   oFrame_cnt
);

  localparam int unsigned CNT_W = (MSG_SIZE > 2) ? $clog2(MSG_SIZE) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MSG_SIZE - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state, stateNext;
  logic [MSG_SIZE-1:0] shreg, shregNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic                msbFirst, msbFirstNext;
  logic                dataNext, bitValidNext, doneNext;
  logic [FCNT_W-1:0]   frameCntNext;

  logic load, shiftEn, lastBit;

  assign load    = (state == IDLE) && iEn && iValid && !iAbort;
  assign shiftEn = (state == SHIFT) && iEn && !iAbort;
  assign lastBit = shiftEn && (cnt == LAST_IDX);

  assign oReady = (state == IDLE);
  assign oBusy  = (state == SHIFT);

  // State and datapath registers
  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      state      <= IDLE;
      shreg      <= '0;
      cnt        <= '0;
      msbFirst   <= 1'b0;
      oData      <= 1'b0;
      oBit_valid <= 1'b0;
      oDone_flag <= 1'b0;
      oFrame_cnt <= '0;
    end else begin
      state      <= stateNext;
      shreg      <= shregNext;
      cnt        <= cntNext;
      msbFirst   <= msbFirstNext;
      oData      <= dataNext;
      oBit_valid <= bitValidNext;
      oDone_flag <= doneNext;
      oFrame_cnt <= frameCntNext;
    end
  end

  // Next-state logic; abort always wins
  always_comb begin
    stateNext = state;
    if (iAbort) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (load)    stateNext = SHIFT;
        SHIFT:   if (lastBit) stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  // Datapath/output next values; strobes default low so stalls never repeat a bit
  always_comb begin
    shregNext    = shreg;
    cntNext      = cnt;
    msbFirstNext = msbFirst;
    dataNext     = oData;
    bitValidNext = 1'b0;
    doneNext     = 1'b0;
    frameCntNext = oFrame_cnt;
    if (iAbort) begin
      cntNext  = '0;
      dataNext = 1'b0;
    end else if (load) begin
      shregNext    = iCiphertext;
      msbFirstNext = iMsb_first;
      cntNext      = '0;
    end else if (shiftEn) begin
      bitValidNext = 1'b1;
      if (msbFirst) begin
        dataNext  = shreg[MSG_SIZE-1];
        shregNext = {shreg[MSG_SIZE-2:0], 1'b0};
      end else begin
        dataNext  = shreg[0];
        shregNext = {1'b0, shreg[MSG_SIZE-1:1]};
      end
      if (lastBit) begin
        doneNext     = 1'b1;
        frameCntNext = oFrame_cnt + FCNT_W'(1);
        cntNext      = '0;
      end else begin
        cntNext = cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_serialize_stream.sv
// Directed bench for serialize_stream: expected bits are queued at load and
// popped as the DUT strobes them; a second FCNT_W=2 instance checks counter wrap.
module tb_serialize_stream;

  localparam int unsigned MSG_SIZE = 8;

  typedef struct packed {
    logic data;
    logic last;
  } expBit_t;

  logic                iClk = 1'b0;
  logic                iRst, iEn, iAbort, iValid, iMsb_first;
  logic [MSG_SIZE-1:0] iCiphertext;
  logic                oReady, oData, oBit_valid, oDone_flag, oBusy;
  logic [7:0]          oFrame_cnt;
  logic                oReady2, oData2, oBitValid2, oDone2, oBusy2;
  logic [1:0]          oFrameCnt2;

  expBit_t    expQ[$];
  logic [7:0] frames;
  int         testCnt = 0;
  int         failCnt = 0;

  serialize_stream #(.MSG_SIZE(MSG_SIZE), .FCNT_W(8)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iAbort(iAbort), .iValid(iValid),
    .oReady(oReady), .iMsb_first(iMsb_first), .iCiphertext(iCiphertext),
    .oData(oData), .oBit_valid(oBit_valid), .oDone_flag(oDone_flag),
    .oBusy(oBusy), .oFrame_cnt(oFrame_cnt)
  );

  serialize_stream #(.MSG_SIZE(MSG_SIZE), .FCNT_W(2)) dut2 (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iAbort(iAbort), .iValid(iValid),
    .oReady(oReady2), .iMsb_first(iMsb_first), .iCiphertext(iCiphertext),
    .oData(oData2), .oBit_valid(oBitValid2), .oDone_flag(oDone2),
    .oBusy(oBusy2), .oFrame_cnt(oFrameCnt2)
  );

  always #5 iClk = ~iClk;

  task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    testCnt++;
    assert (obs === expv) else begin
      failCnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one edge and settle just after it
  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic pushWord(input logic [MSG_SIZE-1:0] w, input logic msb);
    expBit_t e;
    for (int i = 0; i < MSG_SIZE; i++) begin
      e.data = msb ? w[MSG_SIZE-1-i] : w[i];
      e.last = (i == MSG_SIZE - 1);
      expQ.push_back(e);
    end
  endtask

  task automatic doLoad(input logic [MSG_SIZE-1:0] w, input logic msb);
    iCiphertext = w;
    iMsb_first  = msb;
    iValid      = 1'b1;
    iEn         = 1'b1;
    tick();
    iValid = 1'b0;
    pushWord(w, msb);
    checkEq("loadBusy", oBusy, 1'b1);
    checkEq("loadNoStrobe", oBit_valid, 1'b0);
  endtask

  // Consume n strobed bits within a cycle budget, scoring each against the queue
  task automatic runBits(input int n, input int budget);
    int got = 0;
    int cyc = 0;
    expBit_t e;
    while (got < n && cyc < budget) begin
      tick();
      cyc++;
      if (oBit_valid) begin
        if (expQ.size() == 0) begin
          checkEq("spuriousBit", oBit_valid, 1'b0);
        end else begin
          e = expQ.pop_front();
          got++;
          checkEq("data", oData, e.data);
          checkEq("done", oDone_flag, e.last);
          if (e.last) begin
            frames = frames + 8'd1;
            checkEq("frameCnt", oFrame_cnt, frames);
            checkEq("frameCntWrap", oFrameCnt2, frames[1:0]);
          end
        end
      end else begin
        checkEq("doneWithoutBit", oDone_flag, 1'b0);
      end
    end
    if (got < n) checkEq("bitTimeout", got, n);
  endtask

  initial begin
    iRst = 1'b0; iEn = 1'b0; iAbort = 1'b0; iValid = 1'b0;
    iMsb_first = 1'b0; iCiphertext = '0; frames = '0;
    repeat (2) tick();
    checkEq("rstReady", oReady, 1'b1);
    checkEq("rstBusy", oBusy, 1'b0);
    checkEq("rstData", oData, 1'b0);
    checkEq("rstBitValid", oBit_valid, 1'b0);
    checkEq("rstDone", oDone_flag, 1'b0);
    checkEq("rstFrameCnt", oFrame_cnt, 8'd0);
    @(negedge iClk);
    iRst = 1'b1;
    iEn  = 1'b1;

    // LSB-first A5, then MSB-first A5 and 80
    doLoad(8'hA5, 1'b0);
    runBits(8, 8);
    checkEq("readyAfterFrame", oReady, 1'b1);
    doLoad(8'hA5, 1'b1);
    runBits(8, 8);
    doLoad(8'h80, 1'b1);
    runBits(8, 8);

    // Stall for 3 cycles after bit 3 of FF
    doLoad(8'hFF, 1'b1);
    runBits(3, 3);
    iEn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkEq("stallStrobe", oBit_valid, 1'b0);
      checkEq("stallDone", oDone_flag, 1'b0);
      checkEq("stallData", oData, 1'b1);
      checkEq("stallBusy", oBusy, 1'b1);
    end
    iEn = 1'b1;
    runBits(5, 5);
    tick();
    checkEq("noExtraStrobe", oBit_valid, 1'b0);

    // Abort at bit 5 of 3C; mid-frame input changes must be ignored
    doLoad(8'h3C, 1'b0);
    iCiphertext = 8'h00;
    iMsb_first  = 1'b1;
    runBits(5, 5);
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    expQ.delete();
    checkEq("abortIdle", oReady, 1'b1);
    checkEq("abortData", oData, 1'b0);
    checkEq("abortStrobe", oBit_valid, 1'b0);
    checkEq("abortDone", oDone_flag, 1'b0);
    checkEq("abortFrameCnt", oFrame_cnt, frames);

    // Abort in IDLE blocks a load
    iValid = 1'b1;
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    iValid = 1'b0;
    checkEq("abortBlocksLoad", oBusy, 1'b0);
    doLoad(8'h96, 1'b1);
    runBits(8, 8);

    // Back-to-back with iValid held: one frame per MSG_SIZE+1 cycles
    for (int k = 1; k <= 3; k++) begin
      iCiphertext = 8'(k);
      iMsb_first  = 1'b0;
      iValid      = 1'b1;
      tick();
      if (k == 3) iValid = 1'b0;
      pushWord(8'(k), 1'b0);
      checkEq("b2bLoad", oBusy, 1'b1);
      runBits(8, 8);
      checkEq("b2bReady", oReady, 1'b1);
    end

    // Async reset in the middle of bit 4
    doLoad(8'hC3, 1'b1);
    runBits(4, 4);
    #2 iRst = 1'b0;
    #1;
    expQ.delete();
    frames = '0;
    checkEq("asyncRstReady", oReady, 1'b1);
    checkEq("asyncRstBusy", oBusy, 1'b0);
    checkEq("asyncRstData", oData, 1'b0);
    checkEq("asyncRstStrobe", oBit_valid, 1'b0);
    checkEq("asyncRstFrameCnt", oFrame_cnt, 8'd0);
    checkEq("asyncRstFrameCnt2", oFrameCnt2, 2'd0);
    @(negedge iClk);
    iRst = 1'b1;

    // Five frames after reset: 2-bit counter wraps to 1
    doLoad(8'h5A, 1'b1);
    runBits(8, 8);
    doLoad(8'h5A, 1'b0);
    runBits(8, 8);
    for (int k = 0; k < 3; k++) begin
      doLoad(8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      runBits(8, 8);
    end
    checkEq("fiveFrames", oFrame_cnt, 8'd5);
    checkEq("fiveFramesWrap", oFrameCnt2, 2'd1);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end

endmodule
